// File: rtl/sar_afe_responder.sv
// rtl/sar_afe_responder.sv - analog front-end stand-in answering a SAR controller
// Holds the sampled input, answers DAC trials, and checks each conversion result.
module sar_afe_responder #(
  parameter int Width         = 6,
  parameter int CmpLatency    = 1,
  parameter int TimeoutCycles = Width + 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] vin_i,
  input  logic             sample_i,
  input  logic [Width-1:0] dac_i,
  input  logic             eoc_i,
  input  logic [Width-1:0] result_i,
  input  logic             clr_i,
  output logic             cmp_o,
  output logic [Width-1:0] held_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             err_o,
  output logic [7:0]       conv_cnt_o,
  output logic [7:0]       err_cnt_o
);

  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_CONVERT = 2'd2,
    S_CHECK   = 2'd3
  } state_e;

  state_e                r_state;
  logic [Width-1:0]      r_held;
  logic [CmpLatency-1:0] r_cmp_pipe;
  logic [TW-1:0]         r_tmo;
  logic                  r_valid;
  logic                  r_match;
  logic                  r_err;
  logic [7:0]            r_conv_cnt;
  logic [7:0]            r_err_cnt;

  logic w_raw;
  logic w_in_conv;
  logic w_take_check;
  logic w_abort;
  logic w_timeout;
  logic w_mismatch;
  logic w_conv_inc;
  logic w_err_inc;

  // End-of-conversion wins over a re-sample and over the timeout in the same cycle.
  assign w_raw        = (r_held >= dac_i);
  assign w_in_conv    = (r_state == S_CONVERT);
  assign w_take_check = w_in_conv && eoc_i;
  assign w_abort      = w_in_conv && !eoc_i && sample_i;
  assign w_timeout    = w_in_conv && !eoc_i && !sample_i &&
                        (r_tmo == TW'(TimeoutCycles - 1));
  assign w_mismatch   = w_take_check && (result_i != r_held);
  assign w_conv_inc   = w_take_check;
  assign w_err_inc    = w_abort || w_timeout || w_mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_held <= '0;
    end else if (sample_i) begin
      r_held <= vin_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmp_pipe <= '0;
    end else begin
      r_cmp_pipe[0] <= w_raw;
      for (int i = 1; i < CmpLatency; i++) begin
        r_cmp_pipe[i] <= r_cmp_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (sample_i) r_state <= S_TRACK;
        end
        S_TRACK: begin
          if (!sample_i) begin
            r_state <= S_CONVERT;
            r_tmo   <= '0;
          end
        end
        S_CONVERT: begin
          r_tmo <= r_tmo + TW'(1);
          if (eoc_i) begin
            r_state <= S_CHECK;
            r_valid <= 1'b1;
            r_match <= !w_mismatch;
            r_err   <= w_mismatch;
          end else if (sample_i) begin
            r_state <= S_TRACK;
            r_err   <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= sample_i ? S_TRACK : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear beats a same-cycle increment; both counters stick at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conv_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (clr_i) begin
      r_conv_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_conv_inc && (r_conv_cnt != 8'hFF)) r_conv_cnt <= r_conv_cnt + 8'd1;
      if (w_err_inc && (r_err_cnt != 8'hFF))   r_err_cnt  <= r_err_cnt + 8'd1;
    end
  end

  assign cmp_o      = r_cmp_pipe[CmpLatency-1];
  assign held_o     = r_held;
  assign valid_o    = r_valid;
  assign match_o    = r_match;
  assign err_o      = r_err;
  assign conv_cnt_o = r_conv_cnt;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_sar_afe_responder.sv
// tb/tb_sar_afe_responder.sv - randomized self-checking bench for sar_afe_responder
// Expectations come from a transaction-level model: held value, arithmetic compare, saturating counts.
module tb_sar_afe_responder;

  localparam int W   = 6;
  localparam int LAT = 1;
  localparam int TO  = W + 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [W-1:0] vin_i, dac_i, result_i;
  logic         sample_i, eoc_i, clr_i;
  logic         cmp_o, valid_o, match_o, err_o;
  logic [W-1:0] held_o;
  logic [7:0]   conv_cnt_o, err_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int m_held = 0;
  int m_conv = 0;
  int m_err  = 0;

  sar_afe_responder #(.Width(W), .CmpLatency(LAT), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .vin_i(vin_i), .sample_i(sample_i),
    .dac_i(dac_i), .eoc_i(eoc_i), .result_i(result_i), .clr_i(clr_i),
    .cmp_o(cmp_o), .held_o(held_o), .valid_o(valid_o), .match_o(match_o),
    .err_o(err_o), .conv_cnt_o(conv_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Sample, fall, DAC trials, then eoc with the given result; checks the CHECK cycle and after.
  task automatic run_conv(input logic [W-1:0] v, input int ntr, input logic [W-1:0] res,
                          input bit move_vin);
    int d;
    bit exp_ok;
    vin_i = v; sample_i = 1'b1; step();
    m_held = v;
    n_cmp++;
    if (held_o !== W'(m_held)) begin
      n_bad++; $display("FAIL conv_held: got %0d expected %0d", held_o, m_held);
    end
    sample_i = 1'b0;
    if (move_vin) vin_i = W'($urandom);
    step();
    for (int k = 0; k < ntr; k++) begin
      d = $urandom_range(0, 1) ? (m_held + $urandom_range(0, 4) - 2) : $urandom_range(0, 63);
      if (d < 0) d = 0;
      if (d > 63) d = 63;
      dac_i = W'(d);
      step();
      n_cmp++;
      if (cmp_o !== (m_held >= d)) begin
        n_bad++; $display("FAIL conv_cmp: held %0d dac %0d got %0b expected %0b", m_held, d, cmp_o, m_held >= d);
      end
    end
    eoc_i = 1'b1; result_i = res; step();
    exp_ok = (int'(res) == m_held);
    m_conv = sat(m_conv + 1);
    if (!exp_ok) m_err = sat(m_err + 1);
    n_cmp++;
    if ({valid_o, match_o, err_o} !== {1'b1, exp_ok, !exp_ok}) begin
      n_bad++; $display("FAIL conv_flags: got v%0b m%0b e%0b expected v1 m%0b e%0b", valid_o, match_o, err_o, exp_ok, !exp_ok);
    end
    n_cmp++;
    if (conv_cnt_o !== 8'(m_conv) || err_cnt_o !== 8'(m_err)) begin
      n_bad++; $display("FAIL conv_counts: got %0d/%0d expected %0d/%0d", conv_cnt_o, err_cnt_o, m_conv, m_err);
    end
    eoc_i = 1'b0; step();
    n_cmp++;
    if ({valid_o, match_o, err_o} !== 3'b000 || held_o !== W'(m_held)) begin
      n_bad++; $display("FAIL conv_after: got v%0b m%0b e%0b held %0d expected 000 held %0d", valid_o, match_o, err_o, held_o, m_held);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; vin_i = '0; dac_i = '0; result_i = '0;
    sample_i = 1'b0; eoc_i = 1'b0; clr_i = 1'b0;
    #12;
    n_cmp++;
    if ({cmp_o, held_o, valid_o, match_o, err_o, conv_cnt_o, err_cnt_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got held %0d conv %0d err %0d cmp %0b, expected all zero", held_o, conv_cnt_o, err_cnt_o, cmp_o);
    end
    #11 rst_ni = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int trials [6] = '{32, 48, 40, 36, 38, 37};
    bit exp_c  [6] = '{1, 0, 0, 1, 0, 1};
    vin_i = 6'd37; sample_i = 1'b1; step();
    sample_i = 1'b0; step();
    m_held = 37;
    for (int k = 0; k < 6; k++) begin
      dac_i = W'(trials[k]); step();
      n_cmp++;
      if (cmp_o !== exp_c[k]) begin
        n_bad++; $display("FAIL nominal_cmp: dac %0d got %0b expected %0b", trials[k], cmp_o, exp_c[k]);
      end
    end
    eoc_i = 1'b1; result_i = 6'd37; step();
    m_conv = 1;
    n_cmp++;
    if ({valid_o, match_o, err_o} !== 3'b110 || conv_cnt_o !== 8'd1 || err_cnt_o !== 8'd0) begin
      n_bad++; $display("FAIL nominal_check: got v%0b m%0b e%0b conv %0d err %0d expected v1 m1 e0 conv 1 err 0", valid_o, match_o, err_o, conv_cnt_o, err_cnt_o);
    end
    eoc_i = 1'b0; step();
  endtask

  task automatic test_mismatch();
    clr_i = 1'b1; step(); clr_i = 1'b0;
    m_conv = 0; m_err = 0;
    run_conv(6'd37, 3, 6'd36, 1'b0);
    n_cmp++;
    if (conv_cnt_o !== 8'd1 || err_cnt_o !== 8'd1) begin
      n_bad++; $display("FAIL mismatch_counts: got %0d/%0d expected 1/1", conv_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_hold_isolation();
    run_conv(6'd37, 6, 6'd37, 1'b1);
    for (int n = 0; n < 5; n++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      run_conv(v, 5, v, 1'b1);
    end
  endtask

  task automatic test_timeout();
    vin_i = 6'd20; sample_i = 1'b1; step();
    sample_i = 1'b0; step();
    m_held = 20;
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      n_cmp++;
      if (err_o !== (k == TO) || valid_o !== 1'b0) begin
        n_bad++; $display("FAIL timeout_pulse: cycle %0d got e%0b v%0b expected e%0b v0", k, err_o, valid_o, k == TO);
      end
    end
    m_err = sat(m_err + 1);
    n_cmp++;
    if (conv_cnt_o !== 8'(m_conv) || err_cnt_o !== 8'(m_err)) begin
      n_bad++; $display("FAIL timeout_counts: got %0d/%0d expected %0d/%0d", conv_cnt_o, err_cnt_o, m_conv, m_err);
    end
    eoc_i = 1'b1; result_i = 6'd20; step(); step();
    n_cmp++;
    if (valid_o !== 1'b0 || conv_cnt_o !== 8'(m_conv)) begin
      n_bad++; $display("FAIL timeout_idle: got v%0b conv %0d expected v0 conv %0d", valid_o, conv_cnt_o, m_conv);
    end
    eoc_i = 1'b0; step();
  endtask

  task automatic test_abort();
    vin_i = 6'd11; sample_i = 1'b1; step();
    sample_i = 1'b0; step();
    step(); step(); step();
    vin_i = 6'd50; sample_i = 1'b1; step();
    m_held = 50; m_err = sat(m_err + 1);
    n_cmp++;
    if (err_o !== 1'b1 || valid_o !== 1'b0 || err_cnt_o !== 8'(m_err) || conv_cnt_o !== 8'(m_conv)) begin
      n_bad++; $display("FAIL abort_pulse: got e%0b v%0b err %0d conv %0d expected e1 v0 err %0d conv %0d", err_o, valid_o, err_cnt_o, conv_cnt_o, m_err, m_conv);
    end
    sample_i = 1'b0; step();
    eoc_i = 1'b1; result_i = 6'd50; step();
    m_conv = sat(m_conv + 1);
    n_cmp++;
    if ({valid_o, match_o, err_o} !== 3'b110 || conv_cnt_o !== 8'(m_conv)) begin
      n_bad++; $display("FAIL abort_retrack: got v%0b m%0b e%0b conv %0d expected v1 m1 e0 conv %0d", valid_o, match_o, err_o, conv_cnt_o, m_conv);
    end
    eoc_i = 1'b0; step();
  endtask

  task automatic test_eoc_priority();
    vin_i = 6'd29; sample_i = 1'b1; step();
    sample_i = 1'b0; step(); step();
    eoc_i = 1'b1; sample_i = 1'b1; result_i = 6'd29; step();
    m_conv = sat(m_conv + 1);
    n_cmp++;
    if ({valid_o, match_o, err_o} !== 3'b110 || err_cnt_o !== 8'(m_err)) begin
      n_bad++; $display("FAIL prio_sample: got v%0b m%0b e%0b err %0d expected v1 m1 e0 err %0d", valid_o, match_o, err_o, err_cnt_o, m_err);
    end
    eoc_i = 1'b0; step();
    sample_i = 1'b0; step();
    eoc_i = 1'b1; step();
    m_conv = sat(m_conv + 1);
    n_cmp++;
    if (valid_o !== 1'b1 || conv_cnt_o !== 8'(m_conv)) begin
      n_bad++; $display("FAIL prio_check_to_track: got v%0b conv %0d expected v1 conv %0d", valid_o, conv_cnt_o, m_conv);
    end
    eoc_i = 1'b0; step();
    vin_i = 6'd3; sample_i = 1'b1; step();
    sample_i = 1'b0; step();
    for (int k = 1; k < TO; k++) step();
    eoc_i = 1'b1; result_i = 6'd3; step();
    m_conv = sat(m_conv + 1);
    n_cmp++;
    if ({valid_o, match_o, err_o} !== 3'b110) begin
      n_bad++; $display("FAIL prio_timeout: got v%0b m%0b e%0b expected v1 m1 e0", valid_o, match_o, err_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (valid_o !== 1'b0 || err_o !== 1'b0 || conv_cnt_o !== 8'(m_conv)) begin
        n_bad++; $display("FAIL eoc_held: got v%0b e%0b conv %0d expected v0 e0 conv %0d", valid_o, err_o, conv_cnt_o, m_conv);
      end
    end
    eoc_i = 1'b0; step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] v, r;
      v = W'($urandom);
      r = ($urandom_range(0, 2) == 0) ? (v ^ W'($urandom_range(1, 63))) : v;
      run_conv(v, $urandom_range(0, 8), r, $urandom_range(0, 1));
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      logic [W-1:0] v, r;
      v = W'($urandom);
      r = ($urandom_range(0, 1) == 0) ? (v ^ W'($urandom_range(1, 63))) : v;
      run_conv(v, 0, r, 1'b0);
    end
    n_cmp++;
    if (conv_cnt_o !== 8'd255 || err_cnt_o !== 8'(m_err)) begin
      n_bad++; $display("FAIL sat_counts: got %0d/%0d expected 255/%0d", conv_cnt_o, err_cnt_o, m_err);
    end
  endtask

  task automatic test_clear();
    vin_i = 6'd44; sample_i = 1'b1; step();
    sample_i = 1'b0; step();
    eoc_i = 1'b1; clr_i = 1'b1; result_i = 6'd45; step();
    m_conv = 0; m_err = 0;
    n_cmp++;
    if (valid_o !== 1'b1 || conv_cnt_o !== 8'd0 || err_cnt_o !== 8'd0) begin
      n_bad++; $display("FAIL clear_same_cycle: got v%0b conv %0d err %0d expected v1 conv 0 err 0", valid_o, conv_cnt_o, err_cnt_o);
    end
    eoc_i = 1'b0; clr_i = 1'b0; step();
    run_conv(6'd9, 2, 6'd9, 1'b0);
  endtask

  task automatic test_async_reset();
    vin_i = 6'd61; sample_i = 1'b1; step();
    sample_i = 1'b0; dac_i = 6'd10; step(); step();
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    m_conv = 0; m_err = 0; m_held = 0;
    n_cmp++;
    if ({cmp_o, held_o, valid_o, match_o, err_o, conv_cnt_o, err_cnt_o} !== '0) begin
      n_bad++; $display("FAIL async_reset: got held %0d conv %0d err %0d cmp %0b, expected all zero", held_o, conv_cnt_o, err_cnt_o, cmp_o);
    end
    #13 rst_ni = 1'b1;
    for (int k = 0; k < TO + 2; k++) begin
      step();
      n_cmp++;
      if (err_o !== 1'b0 || valid_o !== 1'b0 || err_cnt_o !== 8'd0) begin
        n_bad++; $display("FAIL reset_release: got e%0b v%0b err %0d expected e0 v0 err 0", err_o, valid_o, err_cnt_o);
      end
    end
    run_conv(6'd61, 4, 6'd61, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_hold_isolation();
    test_timeout();
    test_abort();
    test_eoc_priority();
    test_random();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
